// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative signed/unsigned multiply and restoring divide,
//               one bit per cycle on magnitudes, sign fix-up in a final cycle
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_start,
   input  logic             divu_start,
   input  logic             mul_start,
   input  logic             mulu_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_start_q;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_is_div;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_b_zero;
   logic [WIDTH-1:0]     r_a_orig;
   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;
   logic [2*WIDTH-1:0]   r_acc;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_any_start;
   logic                 w_go;
   logic                 w_is_div;
   logic                 w_is_signed;
   logic                 w_sa;
   logic                 w_sb;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH:0]       w_mul_sum;
   logic [WIDTH:0]       w_shift;
   logic [WIDTH:0]       w_trial;
   logic                 w_q_bit;
   logic [WIDTH-1:0]     w_rem;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_remf;

   assign w_any_start = div_start | divu_start | mul_start | mulu_start;
   assign w_go        = w_any_start & ~r_start_q;

   // Priority div > divu > mul > mulu
   assign w_is_div    = div_start | divu_start;
   assign w_is_signed = div_start | (~divu_start & mul_start);
   assign w_sa        = w_is_signed & a[WIDTH-1];
   assign w_sb        = w_is_signed & b[WIDTH-1];
   assign w_abs_a     = w_sa ? -a : a;
   assign w_abs_b     = w_sb ? -b : b;

   // Shift-add step: add multiplicand into the upper half, shift right.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_opb[0] ? r_opa : '0)};

   // Restoring step: shifted remainder < 2*divisor, so 33 bits never alias.
   assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_trial = w_shift - {1'b0, r_opb};
   assign w_q_bit = ~w_trial[WIDTH];
   assign w_rem   = w_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_remf = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_CALC;
         S_CALC:  if (r_cnt == c_last) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_start_q <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_start_q <= w_any_start;
         r_busy    <= (w_next != S_IDLE);
         r_done    <= (r_state == S_FIX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
         r_a_orig <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_go) begin
               r_is_div <= w_is_div;
               r_neg_q  <= w_sa ^ w_sb;
               r_neg_r  <= w_sa;
               r_b_zero <= (b == '0);
               r_a_orig <= a;
               r_opa    <= w_abs_a;
               r_opb    <= w_abs_b;
               r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : '0;
               r_cnt    <= '0;
            end
            S_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_is_div) begin
                  r_acc <= {w_rem, r_acc[WIDTH-2:0], w_q_bit};
               end else begin
                  r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                  r_opb <= {1'b0, r_opb[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               r_cnt <= '0;
               if (!r_is_div) begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end else if (r_b_zero) begin
                  r_hi <= r_a_orig;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_remf;
                  r_lo <= w_quot;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : table-driven and scoreboarded bench for muldiv_unit
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        div_start = 1'b0;
   logic        divu_start = 1'b0;
   logic        mul_start = 1'b0;
   logic        mulu_start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [63:0] sb_q[$];

   typedef struct {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   vec_t vecs[12];

   localparam logic [3:0] c_div  = 4'b1000;
   localparam logic [3:0] c_divu = 4'b0100;
   localparam logic [3:0] c_mul  = 4'b0010;
   localparam logic [3:0] c_mulu = 4'b0001;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .div_start  (div_start),
      .divu_start (divu_start),
      .mul_start  (mul_start),
      .mulu_start (mulu_start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] m);
      {div_start, divu_start, mul_start, mulu_start} = m;
   endtask

   // Scoreboard: every done pulse consumes one expected {hi,lo}.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual={%h,%h} required=no result", hi, lo);
         end else begin
            check("result", {hi, lo}, sb_q.pop_front());
         end
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         if (busy) n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [3:0] m, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] eh, input logic [31:0] el);
      int n;
      int d0;
      @(negedge clk);
      a = ta;
      b = tb_v;
      drive(m);
      sb_q.push_back({eh, el});
      d0 = done_cnt;
      @(negedge clk);
      drive(4'b0000);
      a = $urandom;
      b = $urandom;
      wait_done(n);
      check("busy_cycles", 64'(n), 64'd33);
      check("busy_at_done", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("done_pulse_width", {63'd0, done}, 64'd0);
      check("done_count", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;

      vecs[0]  = '{c_mul,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1]  = '{c_mulu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{c_div,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{c_divu, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4]  = '{c_div,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{c_divu, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      vecs[6]  = '{c_div,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[7]  = '{c_div,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[8]  = '{c_mul,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9]  = '{c_div,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[10] = '{c_mulu, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[11] = '{c_divu, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

      repeat (2) @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         run_op(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].ehi, vecs[i].elo);

      // Start held for 40 cycles, operands changed mid-operation
      @(negedge clk);
      a = 32'd7;
      b = 32'd6;
      drive(c_mul);
      sb_q.push_back({32'd0, 32'd42});
      d0 = done_cnt;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 5) begin
            a = 32'd100;
            b = 32'd100;
         end
      end
      check("held_busy", {63'd0, busy}, 64'd0);
      check("held_launch_count", 64'(done_cnt - d0), 64'd1);
      drive(4'b0000);
      repeat (5) @(negedge clk);
      check("held_no_relaunch", {63'd0, busy}, 64'd0);
      check("held_launch_count_after", 64'(done_cnt - d0), 64'd1);

      // Simultaneous div and mulu: divide wins
      run_op(c_div | c_mulu, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);

      // divu pulse during a busy DIV is ignored
      @(negedge clk);
      a = 32'hFFFFFF9C;
      b = 32'd7;
      drive(c_div);
      sb_q.push_back({32'hFFFFFFFE, 32'hFFFFFFF2});
      d0 = done_cnt;
      @(negedge clk);
      drive(4'b0000);
      repeat (10) @(negedge clk);
      a = 32'd5;
      b = 32'd1;
      drive(c_divu);
      @(negedge clk);
      drive(4'b0000);
      wait_done(n);
      check("ignore_busy_cycles", 64'(n), 64'd22);
      repeat (40) @(negedge clk);
      check("ignore_busy_idle", {63'd0, busy}, 64'd0);
      check("ignore_done_count", 64'(done_cnt - d0), 64'd1);
      check("ignore_hilo_hold", {hi, lo}, {32'hFFFFFFFE, 32'hFFFFFFF2});

      // Asynchronous reset in the middle of a DIVU
      @(negedge clk);
      a = 32'd1000;
      b = 32'd3;
      drive(c_divu);
      @(negedge clk);
      drive(4'b0000);
      repeat (10) @(negedge clk);
      check("pre_reset_busy", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_busy", {63'd0, busy}, 64'd0);
      check("async_reset_done", {63'd0, done}, 64'd0);
      check("async_reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset_idle", {63'd0, busy}, 64'd0);
      run_op(c_mulu, 32'd3, 32'd4, 32'd0, 32'd12);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
